// File: rtl/rgb_mode_sequencer.sv
// LED16 RGB controller: debounced BTNC steps OFF/RED/GREEN/BLUE/CYCLE, SW[3:0] sets PWM duty.
// Optional MODE_LED_EN drives a registered mode code on LED[2:0]; otherwise LED is tied low.
module rgb_mode_sequencer #(
  parameter int unsigned DB_CYCLES   = 1_000_000,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned CYCLE_TICKS = 50_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       BTNU,
  input  logic       BTNC,
  input  logic [3:0] SW,
  output logic       LED16_R,
  output logic       LED16_G,
  output logic       LED16_B,
  output logic [2:0] LED
);

  localparam int unsigned DbW   = $clog2(DB_CYCLES + 1);
  localparam int unsigned TickW = $clog2(CYCLE_TICKS + 1);
  localparam int unsigned Reps  = (PWM_BITS + 3) / 4;
  localparam int unsigned RepW  = 4 * Reps;
  localparam logic [DbW-1:0]   DbMax   = DbW'(DB_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(CYCLE_TICKS - 1);

  typedef enum logic [2:0] {StOff, StRed, StGreen, StBlue, StCycle} mode_e;
  typedef enum logic [1:0] {ColR, ColG, ColB} colour_e;

  logic           btn_sync1, btn_sync2, btn_db, btn_db_q, press;
  logic [DbW-1:0] db_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_db    <= 1'b0;
      btn_db_q  <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_sync1 <= BTNC;
      btn_sync2 <= btn_sync1;
      btn_db_q  <= btn_db;
      if (btn_sync2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DbMax) begin
        btn_db <= btn_sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Only the debounced rising edge counts; releases are ignored.
  assign press = btn_db & ~btn_db_q;

  function automatic mode_e next_mode(mode_e m);
    mode_e n;
    unique case (m)
      StOff:   n = StRed;
      StRed:   n = StGreen;
      StGreen: n = StBlue;
      StBlue:  n = StCycle;
      default: n = StOff;
    endcase
    return n;
  endfunction

`ifdef MODE_LED_EN
  function automatic logic [2:0] mode_code(mode_e m);
    logic [2:0] c;
    unique case (m)
      StRed:   c = 3'b001;
      StGreen: c = 3'b010;
      StBlue:  c = 3'b100;
      StCycle: c = 3'b111;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  logic [2:0] mode_led;
  assign LED = mode_led;
`else
  assign LED = 3'b000;
`endif

  mode_e            mode;
  colour_e          colour;
  logic [TickW-1:0] tick;

  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      mode   <= StOff;
      colour <= ColR;
      tick   <= '0;
`ifdef MODE_LED_EN
      mode_led <= 3'b000;
`endif
    end else if (press) begin
      // A press beats a simultaneous colour step.
      mode   <= next_mode(mode);
      colour <= ColR;
      tick   <= '0;
`ifdef MODE_LED_EN
      mode_led <= mode_code(next_mode(mode));
`endif
    end else if (mode == StCycle) begin
      if (tick == TickMax) begin
        tick <= '0;
        unique case (colour)
          ColR:    colour <= ColG;
          ColG:    colour <= ColB;
          default: colour <= ColR;
        endcase
      end else begin
        tick <= tick + 1'b1;
      end
    end else begin
      colour <= ColR;
      tick   <= '0;
    end
  end

  logic [PWM_BITS-1:0] pwm_cnt, duty, duty_src;
  logic [RepW-1:0]     sw_rep;
  logic                pwm_on, sel_r, sel_g, sel_b;

  assign sw_rep   = {Reps{SW}};
  assign duty_src = sw_rep[RepW-1 -: PWM_BITS];
  assign pwm_on   = (pwm_cnt < duty);

  always_comb begin
    sel_r = 1'b0;
    sel_g = 1'b0;
    sel_b = 1'b0;
    unique case (mode)
      StRed:   sel_r = 1'b1;
      StGreen: sel_g = 1'b1;
      StBlue:  sel_b = 1'b1;
      StCycle: begin
        sel_r = (colour == ColR);
        sel_g = (colour == ColG);
        sel_b = (colour == ColB);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      pwm_cnt <= '0;
      duty    <= '0;
      LED16_R <= 1'b0;
      LED16_G <= 1'b0;
      LED16_B <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      // Duty only moves at the period boundary so a period is never cut short.
      if (&pwm_cnt) duty <= duty_src;
      LED16_R <= pwm_on & sel_r;
      LED16_G <= pwm_on & sel_g;
      LED16_B <= pwm_on & sel_b;
    end
  end

endmodule

// File: tb/tb_rgb_mode_sequencer.sv
// Directed bench for rgb_mode_sequencer with DB_CYCLES=4, CYCLE_TICKS=16, PWM_BITS=8.
module tb_rgb_mode_sequencer;

  logic       clk  = 1'b0;
  logic       btnu = 1'b1;
  logic       btnc = 1'b0;
  logic [3:0] sw   = 4'hF;
  logic       r, g, b;
  logic [2:0] led;

  rgb_mode_sequencer #(
    .DB_CYCLES  (4),
    .PWM_BITS   (8),
    .CYCLE_TICKS(16)
  ) dut (
    .CLK100MHZ(clk),
    .BTNU     (btnu),
    .BTNC     (btnc),
    .SW       (sw),
    .LED16_R  (r),
    .LED16_G  (g),
    .LED16_B  (b),
    .LED      (led)
  );

  always #5 clk = ~clk;

  // Reference PWM phase: value the PWM counter holds after each edge.
  logic [7:0] phase = 8'd0;
  always @(posedge clk) phase <= btnu ? 8'd0 : phase + 8'd1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_led(input string name, input logic [2:0] exp);
`ifdef MODE_LED_EN
    check(name, int'(led), int'(exp));
`else
    check(name, int'(led), 0);
`endif
  endtask

  task automatic press_btn();
    btnc = 1'b1;
    cyc(10);
    btnc = 1'b0;
    cyc(10);
  endtask

  task automatic wait_phase(input logic [7:0] p);
    int w = 0;
    while (phase != p && w < 600) begin
      cyc(1);
      w++;
    end
    if (phase != p) check("phase_wait_timeout", int'(phase), int'(p));
  endtask

  // Counts channel-high samples over one PWM period (cnt 0..255 seen as phase 1..0).
  task automatic measure(input bit align, input int change_at, input logic [3:0] new_sw,
                         output int nr, output int ng, output int nb, output int nmulti);
    nr = 0; ng = 0; nb = 0; nmulti = 0;
    if (align) begin
      wait_phase(8'd128);
      wait_phase(8'd1);
    end
    for (int i = 0; i < 256; i++) begin
      nr += int'(r);
      ng += int'(g);
      nb += int'(b);
      if (int'(r) + int'(g) + int'(b) > 1) nmulti++;
      if (int'(phase) == change_at) sw = new_sw;
      cyc(1);
    end
  endtask

  typedef struct {
    int         presses;
    logic [3:0] sw;
    int         r;
    int         g;
    int         b;
    logic [2:0] led;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nr, ng, nb, nm;
    logic [2:0] exp_rgb;
    logic [2:0] act_rgb;

    vecs[0] = '{0, 4'h4, 68, 0, 0, 3'b001};
    vecs[1] = '{0, 4'h0, 0, 0, 0, 3'b001};
    vecs[2] = '{0, 4'hF, 255, 0, 0, 3'b001};
    vecs[3] = '{0, 4'h1, 17, 0, 0, 3'b001};
    vecs[4] = '{1, 4'h8, 0, 136, 0, 3'b010};
    vecs[5] = '{1, 4'hA, 0, 0, 170, 3'b100};
    vecs[6] = '{0, 4'h8, 0, 0, 136, 3'b100};

    // Reset
    cyc(2);
    check("reset_rgb", int'({r, g, b}), 0);
    check_led("reset_led", 3'b000);
    btnu = 1'b0;

    // Short bounces must not advance the mode
    for (int i = 0; i < 5; i++) begin
      btnc = 1'b1;
      cyc(2);
      btnc = 1'b0;
      cyc(2);
    end
    cyc(10);
    measure(1, -1, 4'h0, nr, ng, nb, nm);
    check("bounce_r", nr, 0);
    check("bounce_g", ng, 0);
    check_led("bounce_led", 3'b000);

    // Held press: exactly one advance to RED
    press_btn();
    measure(1, -1, 4'h0, nr, ng, nb, nm);
    check("hold_r", nr, 255);
    check("hold_g", ng, 0);
    check("hold_b", nb, 0);
    check_led("hold_led", 3'b001);

    for (int v = 0; v < 7; v++) begin
      for (int p = 0; p < vecs[v].presses; p++) press_btn();
      sw = vecs[v].sw;
      measure(1, -1, 4'h0, nr, ng, nb, nm);
      check($sformatf("vec%0d_r", v), nr, vecs[v].r);
      check($sformatf("vec%0d_g", v), ng, vecs[v].g);
      check($sformatf("vec%0d_b", v), nb, vecs[v].b);
      check($sformatf("vec%0d_multi", v), nm, 0);
      check_led($sformatf("vec%0d_led", v), vecs[v].led);
    end

    // Mid-period duty change 0x88 -> 0x22 (mode BLUE)
    measure(1, 100, 4'h2, nr, ng, nb, nm);
    check("glitch_cur_b", nb, 136);
    measure(0, -1, 4'h0, nr, ng, nb, nm);
    check("glitch_next_b", nb, 34);

    // CYCLE: press at k=0 enters CYCLE, second press lands on a colour step
    sw = 4'hF;
    cyc(300);
    btnc = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      cyc(1);
      if (k < 8)       exp_rgb = 3'b001;
      else if (k < 24) exp_rgb = 3'b100;
      else if (k < 40) exp_rgb = 3'b010;
      else if (k < 56) exp_rgb = 3'b001;
      else             exp_rgb = 3'b000;
      if (phase == 8'd0) exp_rgb = 3'b000;
      act_rgb = {r, g, b};
      check($sformatf("cycle_k%0d", k), int'(act_rgb), int'(exp_rgb));
      if (k == 10) btnc = 1'b0;
      if (k == 48) btnc = 1'b1;
      if (k == 58) btnc = 1'b0;
    end
    check_led("cycle_off_led", 3'b000);

    // Reset mid-CYCLE with button held
    for (int p = 0; p < 4; p++) press_btn();
    check_led("cycle_again_led", 3'b111);
    wait_phase(8'd50);
    check("pre_reset_active", int'(|{r, g, b}), 1);
    btnu = 1'b1;
    btnc = 1'b1;
    cyc(1);
    check("midreset_rgb", int'({r, g, b}), 0);
    check_led("midreset_led", 3'b000);
    cyc(1);
    btnu = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check_led($sformatf("post_reset_led_k%0d", k), (k >= 7) ? 3'b001 : 3'b000);
    end
    cyc(12);
    btnc = 1'b0;
    measure(1, -1, 4'h0, nr, ng, nb, nm);
    check("post_reset_r", nr, 255);
    check("post_reset_g", ng, 0);
    check("post_reset_b", nb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, limit 5000000 ns");
    $fatal(1);
  end

endmodule
